// File: rtl/dsp_result_collector.sv
// -----------------------------------------------------------------------------
// dsp_result_collector
//
// Output-side companion to the DSP48A1 operand input register stages.
// Every operation accepted into the DSP pipeline launches a valid token.
// The token travels down a LATENCY-deep shift register, so it reaches the end
// in the same cycle that the matching P/CARRYOUT value is on p_in/carry_in.
// The result is then captured into a small FIFO and offered downstream on a
// ready/valid stream.
//
// Issue is gated by credits. "used" counts buffered results plus operations
// still in flight. An issue is only accepted while used < FIFO_DEPTH, so a
// result arriving at the end of the pipeline always finds a free FIFO slot.
// This holds even while downstream holds m_ready low.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous clear of tracker, FIFO and counters
//   issue_valid  an operand set is presented to the DSP this cycle
//   issue_ready  a credit is available (registered-only path)
//   p_in         DSP P output
//   carry_in     DSP CARRYOUT
//   m_valid      result available at FIFO head
//   m_ready      downstream accepts the head
//   m_data       head result
//   m_carry      head carry
//   used         FIFO occupancy plus in-flight operations
//   drop_err     sticky: issue_valid seen while issue_ready was low
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid and ready are both high.
//   On the issue side, issue_ready depends only on registered state.
//   On the output side, m_valid/m_data/m_carry depend only on registered state.
//   Neither valid may depend combinationally on the opposite ready.
// -----------------------------------------------------------------------------
module dsp_result_collector #(
  parameter int P_WIDTH    = 48,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [P_WIDTH-1:0] p_in,
  input  logic               carry_in,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [P_WIDTH-1:0] m_data,
  output logic               m_carry,
  output logic [CNT_W-1:0]   used,
  output logic               drop_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Token tracker and counters
  logic [LATENCY-1:0] vld_sr;
  logic [LATENCY-1:0] vld_sr_next;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   inflight_next;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;

  // FIFO storage: {carry, P}
  logic [P_WIDTH:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;

  logic accept;
  logic reject;
  logic push;
  logic pop;

  // ---------------------------------------------------------------------------
  // Credit and handshake decode.
  // used/issue_ready come from registers only. A pop therefore frees its
  // credit one cycle later, when count has actually dropped.
  // ---------------------------------------------------------------------------
  assign used        = count + inflight;
  assign issue_ready = (used < DEPTH_C);

  assign accept = issue_valid & issue_ready;
  assign reject = issue_valid & ~issue_ready;

  // The oldest token lines up with the cycle its P value is on p_in.
  assign push = vld_sr[LATENCY-1];

  assign m_valid = (count != '0);
  assign pop     = m_valid & m_ready;

  assign {m_carry, m_data} = mem[rd_ptr];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    vld_sr_next    = vld_sr << 1;
    vld_sr_next[0] = accept;

    inflight_next = inflight;
    case ({accept, push})
      2'b10:   inflight_next = inflight + 1'b1;
      2'b01:   inflight_next = inflight - 1'b1;
      default: inflight_next = inflight;
    endcase

    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control state. flush wins over any accept/push/pop in the same cycle, so
  // tokens still in the pipe are dropped and their results never land.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr   <= '0;
      inflight <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_err <= 1'b0;
    end else if (flush) begin
      vld_sr   <= '0;
      inflight <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_err <= 1'b0;
    end else begin
      vld_sr   <= vld_sr_next;
      inflight <= inflight_next;
      count    <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (reject) begin
        drop_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. It is cleared on reset so the head reads as zero straight out of
  // reset. flush leaves the contents alone, because m_valid already hides them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !flush) begin
      mem[wr_ptr] <= {carry_in, p_in};
    end
  end

endmodule

// File: tb/tb_dsp_result_collector.sv
// -----------------------------------------------------------------------------
// tb_dsp_result_collector
//
// dut_a: default parameters (LATENCY=4, FIFO_DEPTH=4). It covers reset, single
//        issue, backpressure, push/pop with pointer wrap, flush and async reset.
// dut_b: LATENCY=2, FIFO_DEPTH=4, where FIFO_DEPTH > LATENCY. It covers
//        full-throughput streaming.
//
// The bench models each DSP as a pure delay line. Whatever operand is presented
// at edge t shows up on p_in for edge t+LATENCY, whether or not it was accepted.
// Only tokens should turn that into results.
// -----------------------------------------------------------------------------
module tb_dsp_result_collector;

  localparam int LA = 4;
  localparam int LB = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT A signals
  // ---------------------------------------------------------------------------
  logic        a_flush, a_issue_valid, a_issue_ready, a_carry_in;
  logic [47:0] a_p_in;
  logic        a_m_valid, a_m_ready, a_m_carry, a_drop_err;
  logic [47:0] a_m_data;
  logic [3:0]  a_used;

  // DUT B signals
  logic        b_flush, b_issue_valid, b_issue_ready, b_carry_in;
  logic [47:0] b_p_in;
  logic        b_m_valid, b_m_ready, b_m_carry, b_drop_err;
  logic [47:0] b_m_data;
  logic [3:0]  b_used;

  dsp_result_collector #(.P_WIDTH(48), .LATENCY(LA), .FIFO_DEPTH(4), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .issue_valid(a_issue_valid), .issue_ready(a_issue_ready),
    .p_in(a_p_in), .carry_in(a_carry_in),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_carry(a_m_carry),
    .used(a_used), .drop_err(a_drop_err)
  );

  dsp_result_collector #(.P_WIDTH(48), .LATENCY(LB), .FIFO_DEPTH(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .issue_valid(b_issue_valid), .issue_ready(b_issue_ready),
    .p_in(b_p_in), .carry_in(b_carry_in),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_carry(b_m_carry),
    .used(b_used), .drop_err(b_drop_err)
  );

  // ---------------------------------------------------------------------------
  // Bench state
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [48:0] exp_q[$];
  logic [48:0] exp_qb[$];
  logic [48:0] pipe_a [8];
  logic [48:0] pipe_b [8];
  logic [47:0] a_op, b_op;
  logic        a_cy, b_cy;
  int          b_pops, b_first, b_last;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [47:0] op;
    logic        cy;
    logic        mr;
    logic        rdy;
    logic [3:0]  used;
    logic        mv;
    logic        drop;
  } vec_t;

  vec_t vec[$];

  function automatic vec_t mk(input logic fl, input logic iv, input logic [47:0] op,
                              input logic cy, input logic mr, input logic rdy,
                              input logic [3:0] u, input logic mv, input logic drop);
    vec_t r;
    r.fl = fl; r.iv = iv; r.op = op; r.cy = cy; r.mr = mr;
    r.rdy = rdy; r.used = u; r.mv = mv; r.drop = drop;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle. Before the edge, the scoreboard checks the result
  // that is about to be consumed. After the edge, the DSP delay lines advance.
  // ---------------------------------------------------------------------------
  task automatic step();
    if (a_m_valid && a_m_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_extra_out: got 0x%0h, expected no output", {a_m_carry, a_m_data});
      end else begin
        chk($sformatf("a_data_c%0d", cyc), {15'd0, a_m_carry, a_m_data}, {15'd0, exp_q.pop_front()});
      end
    end
    if (b_m_valid && b_m_ready) begin
      if (b_pops == 0) b_first = cyc;
      b_last = cyc;
      b_pops++;
      if (exp_qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_extra_out: got 0x%0h, expected no output", {b_m_carry, b_m_data});
      end else begin
        chk($sformatf("b_data_c%0d", cyc), {15'd0, b_m_carry, b_m_data}, {15'd0, exp_qb.pop_front()});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 7; i > 0; i--) begin
      pipe_a[i] = pipe_a[i-1];
      pipe_b[i] = pipe_b[i-1];
    end
    pipe_a[0]  = {a_cy, a_op};
    pipe_b[0]  = {b_cy, b_op};
    a_p_in     = pipe_a[LA-1][47:0];
    a_carry_in = pipe_a[LA-1][48];
    b_p_in     = pipe_b[LB-1][47:0];
    b_carry_in = pipe_b[LB-1][48];
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int s;

    rst_n = 1'b0;
    a_flush = 0; a_issue_valid = 0; a_m_ready = 0; a_p_in = '0; a_carry_in = 0;
    b_flush = 0; b_issue_valid = 0; b_m_ready = 1; b_p_in = '0; b_carry_in = 0;
    a_op = '0; a_cy = 0; b_op = '0; b_cy = 0;
    b_pops = 0; b_first = 0; b_last = 0;
    for (int i = 0; i < 8; i++) begin
      pipe_a[i] = '0;
      pipe_b[i] = '0;
    end

    // ---- vector table ----
    // Test 1: single issue, LATENCY 4
    vec.push_back(mk(0, 1, 48'h1234, 0, 1, 1, 4'd0, 0, 0));
    for (int i = 0; i < 4; i++) vec.push_back(mk(0, 0, 48'h0, 0, 1, 1, 4'd1, 0, 0));
    vec.push_back(mk(0, 0, 48'h0, 0, 1, 1, 4'd1, 1, 0));
    vec.push_back(mk(0, 0, 48'h0, 0, 1, 1, 4'd0, 0, 0));
    // Test 2: backpressure, issue_valid held high
    vec.push_back(mk(0, 1, 48'h100, 0, 0, 1, 4'd0, 0, 0));
    vec.push_back(mk(0, 1, 48'h101, 1, 0, 1, 4'd1, 0, 0));
    vec.push_back(mk(0, 1, 48'h102, 0, 0, 1, 4'd2, 0, 0));
    vec.push_back(mk(0, 1, 48'h103, 1, 0, 1, 4'd3, 0, 0));
    vec.push_back(mk(0, 1, 48'h104, 0, 0, 0, 4'd4, 0, 0));
    vec.push_back(mk(0, 1, 48'h105, 1, 0, 0, 4'd4, 1, 1));
    vec.push_back(mk(0, 1, 48'h106, 0, 0, 0, 4'd4, 1, 1));
    vec.push_back(mk(0, 1, 48'h107, 1, 0, 0, 4'd4, 1, 1));
    vec.push_back(mk(0, 1, 48'h108, 0, 0, 0, 4'd4, 1, 1));
    vec.push_back(mk(0, 0, 48'h0,   0, 1, 0, 4'd4, 1, 1));
    vec.push_back(mk(0, 0, 48'h0,   0, 1, 1, 4'd3, 1, 1));
    vec.push_back(mk(0, 0, 48'h0,   0, 1, 1, 4'd2, 1, 1));
    vec.push_back(mk(0, 0, 48'h0,   0, 1, 1, 4'd1, 1, 1));
    vec.push_back(mk(0, 0, 48'h0,   0, 1, 1, 4'd0, 0, 1));
    // Test 3: push+pop at count 2, ten results through the wrapping FIFO
    vec.push_back(mk(0, 1, 48'hB0, 0, 0, 1, 4'd0, 0, 1));
    vec.push_back(mk(0, 1, 48'hB1, 1, 0, 1, 4'd1, 0, 1));
    vec.push_back(mk(0, 1, 48'hB2, 0, 0, 1, 4'd2, 0, 1));
    vec.push_back(mk(0, 0, 48'h0,  0, 0, 1, 4'd3, 0, 1));
    vec.push_back(mk(0, 0, 48'h0,  0, 0, 1, 4'd3, 0, 1));
    vec.push_back(mk(0, 0, 48'h0,  0, 0, 1, 4'd3, 1, 1));
    vec.push_back(mk(0, 0, 48'h0,  0, 1, 1, 4'd3, 1, 1));
    vec.push_back(mk(0, 1, 48'hB3, 1, 1, 1, 4'd2, 1, 1));
    vec.push_back(mk(0, 1, 48'hB4, 0, 1, 1, 4'd2, 1, 1));
    vec.push_back(mk(0, 1, 48'hB5, 1, 1, 1, 4'd2, 0, 1));
    vec.push_back(mk(0, 1, 48'hB6, 0, 1, 1, 4'd3, 0, 1));
    vec.push_back(mk(0, 0, 48'h0,  0, 1, 0, 4'd4, 0, 1));
    vec.push_back(mk(0, 0, 48'h0,  0, 1, 0, 4'd4, 1, 1));
    vec.push_back(mk(0, 1, 48'hB7, 1, 1, 1, 4'd3, 1, 1));
    vec.push_back(mk(0, 1, 48'hB8, 0, 1, 1, 4'd3, 1, 1));
    vec.push_back(mk(0, 1, 48'hB9, 1, 1, 1, 4'd3, 1, 1));
    vec.push_back(mk(0, 0, 48'h0,  0, 1, 1, 4'd3, 0, 1));
    vec.push_back(mk(0, 0, 48'h0,  0, 1, 1, 4'd3, 0, 1));
    vec.push_back(mk(0, 0, 48'h0,  0, 1, 1, 4'd3, 1, 1));
    vec.push_back(mk(0, 0, 48'h0,  0, 1, 1, 4'd2, 1, 1));
    vec.push_back(mk(0, 0, 48'h0,  0, 1, 1, 4'd1, 1, 1));
    vec.push_back(mk(0, 0, 48'h0,  0, 1, 1, 4'd0, 0, 1));
    // Test 5: flush with 2 buffered + 1 in flight and a concurrent issue
    vec.push_back(mk(0, 1, 48'hF0, 0, 0, 1, 4'd0, 0, 1));
    vec.push_back(mk(0, 1, 48'hF1, 0, 0, 1, 4'd1, 0, 1));
    vec.push_back(mk(0, 0, 48'h0,  0, 0, 1, 4'd2, 0, 1));
    vec.push_back(mk(0, 0, 48'h0,  0, 0, 1, 4'd2, 0, 1));
    vec.push_back(mk(0, 1, 48'hF2, 0, 0, 1, 4'd2, 0, 1));
    vec.push_back(mk(0, 0, 48'h0,  0, 0, 1, 4'd3, 1, 1));
    vec.push_back(mk(1, 1, 48'hF3, 0, 0, 1, 4'd3, 1, 1));
    for (int i = 0; i < 6; i++) vec.push_back(mk(0, 0, 48'h0, 0, 1, 1, 4'd0, 0, 0));

    // ---- reset ----
    step();
    step();
    chk("rst_m_valid", {63'd0, a_m_valid}, 64'd0);
    chk("rst_m_data", {16'd0, a_m_data}, 64'd0);
    chk("rst_m_carry", {63'd0, a_m_carry}, 64'd0);
    chk("rst_used", {60'd0, a_used}, 64'd0);
    chk("rst_drop_err", {63'd0, a_drop_err}, 64'd0);
    chk("rst_b_used", {60'd0, b_used}, 64'd0);
    rst_n = 1'b1;
    chk("rst_issue_ready", {63'd0, a_issue_ready}, 64'd1);
    chk("rst_b_issue_ready", {63'd0, b_issue_ready}, 64'd1);

    // ---- table-driven tests 1, 2, 3, 5 ----
    for (int i = 0; i < vec.size(); i++) begin
      a_flush       = vec[i].fl;
      a_issue_valid = vec[i].iv;
      a_op          = vec[i].op;
      a_cy          = vec[i].cy;
      a_m_ready     = vec[i].mr;
      chk($sformatf("r%0d_issue_ready", i), {63'd0, a_issue_ready}, {63'd0, vec[i].rdy});
      chk($sformatf("r%0d_used", i), {60'd0, a_used}, {60'd0, vec[i].used});
      chk($sformatf("r%0d_m_valid", i), {63'd0, a_m_valid}, {63'd0, vec[i].mv});
      chk($sformatf("r%0d_drop_err", i), {63'd0, a_drop_err}, {63'd0, vec[i].drop});
      if (vec[i].iv && vec[i].rdy && !vec[i].fl) exp_q.push_back({vec[i].cy, vec[i].op});
      step();
      if (vec[i].fl) exp_q.delete();
    end
    a_flush = 0; a_issue_valid = 0; a_op = '0; a_cy = 0; a_m_ready = 1;
    chk("a_sb_empty", 64'(exp_q.size()), 64'd0);

    // ---- test 4: streaming on dut_b ----
    b_m_ready = 1;
    s = cyc;
    for (int k = 0; k < 20; k++) begin
      b_issue_valid = 1;
      b_op = 48'(k);
      b_cy = (k % 2 == 1);
      chk($sformatf("b_issue_ready_k%0d", k), {63'd0, b_issue_ready}, 64'd1);
      exp_qb.push_back({b_cy, b_op});
      step();
    end
    b_issue_valid = 0; b_op = '0; b_cy = 0;
    for (int n = 0; n < 10 && exp_qb.size() != 0; n++) step();
    chk("b_drained", 64'(exp_qb.size()), 64'd0);
    chk("b_pops", 64'(b_pops), 64'd20);
    chk("b_first_latency", 64'(b_first - s), 64'd3);
    chk("b_no_gap", 64'(b_last - b_first), 64'd19);
    chk("b_drop_err", {63'd0, b_drop_err}, 64'd0);
    chk("b_used_end", {60'd0, b_used}, 64'd0);

    // ---- test 6: async reset mid-operation ----
    a_m_ready = 0;
    a_issue_valid = 1;
    for (int k = 0; k < 6; k++) begin
      a_op = 48'h0000_6600_0000 + 48'(k);
      a_cy = (k == 0);
      step();
    end
    a_issue_valid = 0; a_op = '0; a_cy = 0;
    chk("ar_pre_m_valid", {63'd0, a_m_valid}, 64'd1);
    chk("ar_pre_head", {15'd0, a_m_carry, a_m_data}, {15'd0, 1'b1, 48'h0000_6600_0000});
    chk("ar_pre_used", {60'd0, a_used}, 64'd4);
    chk("ar_pre_drop_err", {63'd0, a_drop_err}, 64'd1);
    chk("ar_pre_issue_ready", {63'd0, a_issue_ready}, 64'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_m_valid", {63'd0, a_m_valid}, 64'd0);
    chk("ar_m_data", {16'd0, a_m_data}, 64'd0);
    chk("ar_m_carry", {63'd0, a_m_carry}, 64'd0);
    chk("ar_used", {60'd0, a_used}, 64'd0);
    chk("ar_drop_err", {63'd0, a_drop_err}, 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("ar_post_issue_ready", {63'd0, a_issue_ready}, 64'd1);
    chk("ar_post_m_valid", {63'd0, a_m_valid}, 64'd0);

    // ---- report ----
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
